// File: rtl/apb_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter, bundled into one port.
// The arbiter uses the slave modport; the requesters and APB slave use master.
interface apb_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [3*NUM_REQ-1:0]  req_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic [2:0]            paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [15:0]           pwdata;
  logic                  pready;
  logic [15:0]           prdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           paddr, psel, penable, pwrite, pwdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB register port between NUM_REQ requesters,
// one SETUP/ACCESS transfer per accepted request, with a bounded pready wait.
module apb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         preset,
  apb_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        last_q, last_d, pick;
  logic                 found;
  logic [2:0]           addr_q, addr_d;
  logic                 write_q, write_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d, ready;
  logic [15:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  // Search upward from last_q+1 with wrap; the previous winner is checked last.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ready       = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ready[pick] = 1'b1;
          last_d      = pick;
          addr_d      = bus.req_addr[3*pick +: 3];
          write_d     = bus.req_write[pick];
          wdata_d     = bus.req_write[pick] ? bus.req_wdata[16*pick +: 16] : 16'h0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d[last_q] = 1'b1;
          rdata_d             = write_q ? 16'h0 : bus.prdata;
          err_d               = 1'b0;
          state_d             = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rsp_valid_d[last_q] = 1'b1;
          rdata_d             = 16'h0;
          err_d               = 1'b1;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Accept pulses are suppressed while reset is held so every output reads 0.
  assign bus.req_ready = preset ? '0 : ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.psel      = (state_q != IDLE);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.paddr     = addr_q;
  assign bus.pwrite    = write_q;
  assign bus.pwdata    = wdata_q;
endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: a transfer-age model checked every cycle, plus directed
// transfers with literal expectations for reset, writes, waits, fairness and timeout.
module tb_apb_arbiter;
  localparam int NR = 2;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_arbiter_if #(.NUM_REQ(NR)) bus ();

  apb_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR] === 1'b1) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Model: a transfer is tracked by its age in cycles since acceptance.
  bit            m_busy;
  int            m_age, m_last, m_pick;
  logic [2:0]    m_addr;
  logic          m_wr, m_err;
  logic [15:0]   m_wd, m_rdata;
  logic [NR-1:0] m_rspv;

  assign m_pick = rr_pick(m_last, bus.req_valid);

  always @(posedge pclk) begin
    if (preset) begin
      m_busy <= 1'b0; m_age <= 0; m_last <= NR - 1;
      m_addr <= '0; m_wr <= 1'b0; m_wd <= '0;
      m_rspv <= '0; m_rdata <= '0; m_err <= 1'b0;
    end else begin
      m_rspv <= '0;
      if (!m_busy) begin
        if (m_pick >= 0) begin
          m_last <= m_pick;
          m_addr <= bus.req_addr[3*m_pick +: 3];
          m_wr   <= bus.req_write[m_pick];
          m_wd   <= bus.req_write[m_pick] ? bus.req_wdata[16*m_pick +: 16] : 16'h0;
          m_busy <= 1'b1;
          m_age  <= 1;
        end
      end else if (m_age >= 2 && bus.pready) begin
        m_rspv <= oh(m_last); m_rdata <= m_wr ? 16'h0 : bus.prdata;
        m_err <= 1'b0; m_busy <= 1'b0;
      end else if (m_age >= 2 && TO != 0 && m_age == TO + 1) begin
        m_rspv <= oh(m_last); m_rdata <= 16'h0; m_err <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("m_req_ready", bus.req_ready,
          (!m_busy && !preset && m_pick >= 0) ? oh(m_pick) : '0);
      chk("m_busy", bus.busy, m_busy);
      chk("m_psel", bus.psel, m_busy);
      chk("m_penable", bus.penable, m_busy && m_age >= 2);
      chk("m_paddr", bus.paddr, m_addr);
      chk("m_pwrite", bus.pwrite, m_wr);
      chk("m_pwdata", bus.pwdata, m_wd);
      chk("m_rsp_valid", bus.rsp_valid, m_rspv);
      chk("m_rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("m_rsp_err", bus.rsp_err, m_err);
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input int r, input bit wr, input logic [2:0] a, input logic [15:0] d);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_write[r] = wr;
    bus.req_addr[3*r +: 3] = a;
    bus.req_wdata[16*r +: 16] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_idle", bus.busy, 1'b0);
  endtask

  logic [NR-1:0] gr [6];
  int            gc [6];
  int            ng;

  initial begin
    bus.req_valid = '1; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.pready = 1'b0; bus.prdata = '0;

    // Reset held for 3 edges with both requesters pending
    cyc(); chk_en = 1'b1; cyc(); cyc();
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    preset = 1'b0;
    bus.pready = 1'b1; bus.prdata = 16'hBEEF;
    #1 chk("rst_first_grant", bus.req_ready, 2'b01);
    cyc(); bus.req_valid = '0;
    wait_idle();

    // Zero-wait write from requester 1
    drive(1, 1'b1, 3'd5, 16'hA5C3);
    #1 chk("wr_ready", bus.req_ready, 2'b10);
    cyc(); bus.req_valid = '0;
    chk("wr_setup_psel", bus.psel, 1'b1);
    chk("wr_setup_penable", bus.penable, 1'b0);
    cyc();
    chk("wr_access_penable", bus.penable, 1'b1);
    chk("wr_paddr", bus.paddr, 3'd5);
    chk("wr_pwrite", bus.pwrite, 1'b1);
    chk("wr_pwdata", bus.pwdata, 16'hA5C3);
    cyc();
    chk("wr_rsp_valid", bus.rsp_valid, 2'b10);
    chk("wr_rsp_err", bus.rsp_err, 1'b0);

    // Both requesters pending for 6 transfers
    bus.req_write = '0; bus.req_addr = {3'd6, 3'd1}; bus.prdata = 16'h0042;
    bus.req_valid = '1;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.req_ready != '0 && ng < 6) begin
        gr[ng] = bus.req_ready; gc[ng] = c; ng++;
      end
      if (ng == 6) break;
      cyc();
    end
    cyc(); bus.req_valid = '0;
    chk("rr_count", ng, 6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", gr[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("rr_spacing", gc[i] - gc[i-1], 3);
    end
    wait_idle();

    // Read from requester 0 with 3 wait states
    bus.pready = 1'b0;
    drive(0, 1'b0, 3'd2, 16'hFFFF);
    cyc(); bus.req_valid = '0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("rd_penable", bus.penable, 1'b1);
      chk("rd_paddr", bus.paddr, 3'd2);
      if (i == 3) begin bus.pready = 1'b1; bus.prdata = 16'h1234; end
      cyc();
    end
    chk("rd_rsp_valid", bus.rsp_valid, 2'b01);
    chk("rd_rsp_rdata", bus.rsp_rdata, 16'h1234);
    chk("rd_rsp_err", bus.rsp_err, 1'b0);
    chk("rd_penable_off", bus.penable, 1'b0);

    // Timeout: pready stuck low for requester 1
    bus.pready = 1'b0;
    drive(1, 1'b0, 3'd7, 16'h0);
    cyc(); bus.req_valid = '0;
    cyc();
    for (int i = 0; i < TO; i++) begin
      chk("to_penable", bus.penable, 1'b1);
      cyc();
    end
    chk("to_rsp_valid", bus.rsp_valid, 2'b10);
    chk("to_rsp_err", bus.rsp_err, 1'b1);
    chk("to_rsp_rdata", bus.rsp_rdata, 16'h0);
    chk("to_penable_off", bus.penable, 1'b0);
    bus.pready = 1'b1;
    drive(0, 1'b1, 3'd4, 16'h0F0F);
    #1 chk("to_next_ready", bus.req_ready, 2'b01);
    cyc(); bus.req_valid = '0;
    cyc(); cyc();
    chk("to_next_rsp", bus.rsp_valid, 2'b01);
    chk("to_next_err", bus.rsp_err, 1'b0);

    // Reset during ACCESS
    bus.pready = 1'b0;
    drive(0, 1'b1, 3'd3, 16'h7777);
    cyc(); bus.req_valid = '0;
    cyc();
    chk("mr_in_access", bus.penable, 1'b1);
    preset = 1'b1;
    cyc();
    chk("mr_psel", bus.psel, 1'b0);
    chk("mr_penable", bus.penable, 1'b0);
    chk("mr_rsp_valid", bus.rsp_valid, 2'b00);
    chk("mr_busy", bus.busy, 1'b0);
    cyc();
    chk("mr_rsp_valid2", bus.rsp_valid, 2'b00);
    preset = 1'b0;
    bus.req_valid = '1; bus.pready = 1'b1;
    #1 chk("mr_grant_reset", bus.req_ready, 2'b01);
    cyc(); bus.req_valid = '0;
    wait_idle();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
    $fatal(1);
  end
endmodule
